// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Package : mips_pkg
//  Brief   : Opcode/funct constants, ALU operation encodings and the layout
//            of the control bundle shared by the decode stage and its users.
//  Rev     : 1.0  initial release
// ============================================================================
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // ALU operation carried in the control bundle; zero means "no operation"
  typedef enum logic [3:0] {
    ALU_NOP = 4'h0,
    ALU_ADD = 4'h1,
    ALU_SUB = 4'h2,
    ALU_AND = 4'h3,
    ALU_OR  = 4'h4,
    ALU_XOR = 4'h5,
    ALU_NOR = 4'h6,
    ALU_SLT = 4'h7,
    ALU_SLL = 4'h8,
    ALU_SRL = 4'h9,
    ALU_SRA = 4'hA,
    ALU_LUI = 4'hB
  } aluop_e;

  // Control bundle layout: {regwrite, memread, memwrite, memtoreg,
  //                         alusrc, branch, regdst, aluop[3:0]}
  localparam int CTRL_W        = 11;
  localparam int CTRL_ALUOP_LSB = 0;
  localparam int CTRL_ALUOP_W  = 4;
  localparam int CTRL_REGDST   = 4;
  localparam int CTRL_BRANCH   = 5;
  localparam int CTRL_ALUSRC   = 6;
  localparam int CTRL_MEMTOREG = 7;
  localparam int CTRL_MEMWRITE = 8;
  localparam int CTRL_MEMREAD  = 9;
  localparam int CTRL_REGWRITE = 10;

  // Instructions that read rt as a source operand (not just as a destination)
  function automatic logic opcode_uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_unit
//  Brief   : Combinational stall detection against the instruction in EX.
//            Stalls on a load-use dependency, or on any EX-produced value
//            needed by a branch resolved here in ID.
//  Rev     : 1.0  initial release
// ============================================================================
module hazard_unit #(
  parameter int RA_W = 5
) (
  input  logic            in_valid_i,
  input  logic [RA_W-1:0] rs_i,
  input  logic [RA_W-1:0] rt_i,
  input  logic            uses_rt_i,
  input  logic            is_branch_i,
  input  logic            ex_regwrite_i,
  input  logic            ex_memread_i,
  input  logic [RA_W-1:0] ex_rd_i,
  output logic            stall_o
);

  logic w_dep;
  logic w_cause;

  // Dependency on EX's destination combined with the kind of EX producer
  always_comb begin
    w_dep   = (ex_rd_i != '0) && ((ex_rd_i == rs_i) || (uses_rt_i && (ex_rd_i == rt_i)));
    w_cause = ex_memread_i || (ex_regwrite_i && is_branch_i);
    stall_o = in_valid_i && w_dep && w_cause;
  end

endmodule
`default_nettype wire

// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module  : id_stage_pipe
//  Brief   : MIPS-style instruction decode stage: register file with optional
//            writeback bypass, control decode, in-ID branch resolution,
//            hazard stall and a valid/ready ID/EX pipeline register.
//  Rev     : 1.0  initial release
// ============================================================================
module id_stage_pipe
  import mips_pkg::*;
#(
  parameter  int XLEN      = 32,
  parameter  int NREG      = 32,
  parameter  int WB_BYPASS = 1,
  localparam int RA_W      = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc4,
  input  logic              wb_we,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [RA_W-1:0]   ex_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rs_data,
  output logic [XLEN-1:0]   out_rt_data,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_pc4,
  output logic [RA_W-1:0]   out_rs,
  output logic [RA_W-1:0]   out_rt,
  output logic [RA_W-1:0]   out_dst,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              branch_taken,
  output logic [XLEN-1:0]   branch_target,
  output logic              flush_if
);

  // --------------------------------------------------------------------------
  // Instruction fields
  // --------------------------------------------------------------------------
  logic [5:0]      w_op;
  logic [5:0]      w_funct;
  logic [RA_W-1:0] w_rs;
  logic [RA_W-1:0] w_rt;
  logic [RA_W-1:0] w_rd;
  logic [XLEN-1:0] w_imm;

  assign w_op    = in_instr[31:26];
  assign w_funct = in_instr[5:0];
  assign w_rs    = RA_W'(in_instr[25:21]);
  assign w_rt    = RA_W'(in_instr[20:16]);
  assign w_rd    = RA_W'(in_instr[15:11]);
  assign w_imm   = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] regs_q [NREG];
  logic            w_wb_fire;
  logic [XLEN-1:0] w_rs_data;
  logic [XLEN-1:0] w_rt_data;

  assign w_wb_fire = wb_we && (wb_rd != '0);

  // Writeback into the array; r0 is never written so it stays zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (w_wb_fire) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  generate
    if (WB_BYPASS != 0) begin : g_wb_bypass
      // Read ports with same-cycle forwarding of the writeback value
      always_comb begin
        w_rs_data = regs_q[w_rs];
        w_rt_data = regs_q[w_rt];
        if (w_wb_fire && (wb_rd == w_rs)) w_rs_data = wb_data;
        if (w_wb_fire && (wb_rd == w_rt)) w_rt_data = wb_data;
        if (w_rs == '0) w_rs_data = '0;
        if (w_rt == '0) w_rt_data = '0;
      end
    end else begin : g_no_bypass
      // Read ports return the stored value only
      always_comb begin
        w_rs_data = (w_rs == '0) ? '0 : regs_q[w_rs];
        w_rt_data = (w_rt == '0) ? '0 : regs_q[w_rt];
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Control decode; anything unrecognised becomes an all-zero NOP bundle
  // --------------------------------------------------------------------------
  logic [CTRL_W-1:0] w_ctrl;
  aluop_e            w_alu;
  logic              w_is_branch;
  logic              w_uses_rt;

  // Opcode/funct to control bundle
  always_comb begin
    w_ctrl = '0;
    w_alu  = ALU_NOP;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADD, FN_ADDU: w_alu = ALU_ADD;
          FN_SUB, FN_SUBU: w_alu = ALU_SUB;
          FN_AND:          w_alu = ALU_AND;
          FN_OR:           w_alu = ALU_OR;
          FN_XOR:          w_alu = ALU_XOR;
          FN_NOR:          w_alu = ALU_NOR;
          FN_SLT:          w_alu = ALU_SLT;
          FN_SLL:          w_alu = ALU_SLL;
          FN_SRL:          w_alu = ALU_SRL;
          FN_SRA:          w_alu = ALU_SRA;
          default:         w_alu = ALU_NOP;
        endcase
        if (w_alu != ALU_NOP) begin
          w_ctrl[CTRL_REGWRITE] = 1'b1;
          w_ctrl[CTRL_REGDST]   = 1'b1;
        end
      end
      OP_LW: begin
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_ctrl[CTRL_MEMREAD]  = 1'b1;
        w_ctrl[CTRL_MEMTOREG] = 1'b1;
        w_ctrl[CTRL_ALUSRC]   = 1'b1;
        w_alu                 = ALU_ADD;
      end
      OP_SW: begin
        w_ctrl[CTRL_MEMWRITE] = 1'b1;
        w_ctrl[CTRL_ALUSRC]   = 1'b1;
        w_alu                 = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        w_ctrl[CTRL_BRANCH] = 1'b1;
        w_alu               = ALU_SUB;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: begin
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_ctrl[CTRL_ALUSRC]   = 1'b1;
        case (w_op)
          OP_ANDI: w_alu = ALU_AND;
          OP_ORI:  w_alu = ALU_OR;
          OP_SLTI: w_alu = ALU_SLT;
          OP_LUI:  w_alu = ALU_LUI;
          default: w_alu = ALU_ADD;
        endcase
      end
      default: begin
        w_ctrl = '0;
        w_alu  = ALU_NOP;
      end
    endcase
    w_ctrl[CTRL_ALUOP_LSB +: CTRL_ALUOP_W] = w_alu;
  end

  assign w_is_branch = (w_op == OP_BEQ) || (w_op == OP_BNE);
  assign w_uses_rt   = opcode_uses_rt(w_op);

  // --------------------------------------------------------------------------
  // Hazard detection and handshake
  // --------------------------------------------------------------------------
  logic w_hazard;
  logic w_advance;
  logic w_accept;
  logic out_valid_q;

  hazard_unit #(
    .RA_W (RA_W)
  ) u_hazard (
    .in_valid_i    (in_valid),
    .rs_i          (w_rs),
    .rt_i          (w_rt),
    .uses_rt_i     (w_uses_rt),
    .is_branch_i   (w_is_branch),
    .ex_regwrite_i (ex_regwrite),
    .ex_memread_i  (ex_memread),
    .ex_rd_i       (ex_rd),
    .stall_o       (w_hazard)
  );

  assign w_advance = !out_valid_q || out_ready;
  assign in_ready  = w_advance && !w_hazard;
  assign w_accept  = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Branch resolution on the (bypassed) read data
  // --------------------------------------------------------------------------
  logic w_eq;

  assign w_eq          = (w_rs_data == w_rt_data);
  assign branch_taken  = in_valid && !w_hazard &&
                         (((w_op == OP_BEQ) && w_eq) || ((w_op == OP_BNE) && !w_eq));
  assign branch_target = in_pc4 + (w_imm << 2);
  assign flush_if      = branch_taken && w_accept;

  // --------------------------------------------------------------------------
  // ID/EX pipeline register
  // --------------------------------------------------------------------------
  logic [XLEN-1:0]   rs_data_q, rt_data_q, imm_q, pc4_q;
  logic [RA_W-1:0]   rs_q, rt_q, dst_q;
  logic [CTRL_W-1:0] ctrl_q;

  // Load on accept, bubble when the slot drains with nothing new, hold otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      pc4_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      dst_q       <= '0;
      ctrl_q      <= '0;
    end else if (w_advance) begin
      out_valid_q <= w_accept;
      if (w_accept) begin
        rs_data_q <= w_rs_data;
        rt_data_q <= w_rt_data;
        imm_q     <= w_imm;
        pc4_q     <= in_pc4;
        rs_q      <= w_rs;
        rt_q      <= w_rt;
        dst_q     <= w_ctrl[CTRL_REGDST] ? w_rd : w_rt;
        ctrl_q    <= w_ctrl;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_rs_data = rs_data_q;
  assign out_rt_data = rt_data_q;
  assign out_imm     = imm_q;
  assign out_pc4     = pc4_q;
  assign out_rs      = rs_q;
  assign out_rt      = rt_q;
  assign out_dst     = dst_q;
  assign out_ctrl    = ctrl_q;

endmodule
`default_nettype wire
